nested_sqrt_pipe: RTL and testbench



---
 rtl/nested_sqrt_pipe.sv | 209 ++++++++++++++++++++
 tb/tb_nested_sqrt_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/nested_sqrt_pipe.sv
// Pipelined N-level nested integer square root: r = isqrt(t0 + isqrt(t1 + ... isqrt(tN-1))).
// Optional saturating adders with overflow tracking: define NESTED_SQRT_SAT_EN.

module isqrt #(
  parameter int n_pipe_stages = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [31:0] y
);
  localparam int S = n_pipe_stages;

  typedef struct packed {
    logic [31:0] op;
    logic [31:0] rt;
  } sq_t;

  // Digit-by-digit root; each stage runs its share [lo, hi) of the 16 iterations.
  function automatic sq_t f_step(input sq_t st, input int lo, input int hi);
    sq_t         t;
    logic [31:0] one;
    t = st;
    for (int it = 0; it < 16; it++) begin
      if (it >= lo && it < hi) begin
        one = 32'h4000_0000 >> (2 * it);
        if (t.op >= t.rt + one) begin
          t.op = t.op - (t.rt + one);
          t.rt = (t.rt >> 1) + one;
        end else begin
          t.rt = t.rt >> 1;
        end
      end
    end
    return t;
  endfunction

  function automatic logic [31:0] f_root(input sq_t st, input int lo, input int hi);
    sq_t t;
    t = f_step(st, lo, hi);
    return t.rt;
  endfunction

  for (genvar s = 0; s < S; s++) begin : g_st
    localparam int LO = s * 16 / S;
    localparam int HI = (s + 1) * 16 / S;
    sq_t  w_in;
    logic w_vin;
    logic r_v;

    if (s == 0) begin : g_first
      assign w_in  = '{op: x, rt: 32'd0};
      assign w_vin = x_vld;
    end else begin : g_next
      assign w_in  = g_st[s-1].g_mid.r_st;
      assign w_vin = g_st[s-1].r_v;
    end

    always_ff @(posedge clk) begin
      if (rst) r_v <= 1'b0;
      else     r_v <= w_vin;
    end

    if (s < S - 1) begin : g_mid
      sq_t r_st;
      always_ff @(posedge clk) begin
        if (w_vin) r_st <= f_step(w_in, LO, HI);
      end
    end else begin : g_last
      logic [31:0] r_rt;
      always_ff @(posedge clk) begin
        if (w_vin) r_rt <= f_root(w_in, LO, HI);
      end
    end
  end

  assign y_vld = g_st[S-1].r_v;
  assign y     = g_st[S-1].g_last.r_rt;
endmodule

module nested_sqrt_pipe #(
  parameter int N_LEVELS     = 3,
  parameter int ISQRT_STAGES = 16,
  localparam int L   = N_LEVELS * ISQRT_STAGES + (N_LEVELS - 1),
  localparam int IFW = $clog2(L + 2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arg_vld,
  input  logic [32*N_LEVELS-1:0] args,
  output logic                  res_vld,
  output logic [31:0]           res,
  output logic                  res_ovf,
  output logic [IFW-1:0]        in_flight,
  output logic                  idle
);
  localparam int S = ISQRT_STAGES;

  logic [31:0] w_y   [N_LEVELS];
  logic        w_yv  [N_LEVELS];
`ifdef NESTED_SQRT_SAT_EN
  logic        w_ovf [N_LEVELS];
`endif

  for (genvar k = 0; k < N_LEVELS; k++) begin : g_lvl
    if (k == 0) begin : g_inner
      isqrt #(.n_pipe_stages(S)) u_isqrt (
        .clk(clk), .rst(rst),
        .x_vld(arg_vld), .x(args[32*(N_LEVELS-1) +: 32]),
        .y_vld(w_yv[0]), .y(w_y[0])
      );
`ifdef NESTED_SQRT_SAT_EN
      assign w_ovf[0] = 1'b0;
`endif
    end else begin : g_outer
      // One register short of the full delay: the adder register supplies the last cycle.
      localparam int DL = k * (S + 1) - 1;
      localparam int TJ = N_LEVELS - 1 - k;
      logic [DL-1:0] r_dv;
      logic [31:0]   r_dd [DL];
      logic [31:0]   r_x;
      logic          r_xv;
      logic [31:0]   w_xin;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_dv <= '0;
        end else begin
          r_dv[0] <= arg_vld;
          for (int i = 1; i < DL; i++) r_dv[i] <= r_dv[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (arg_vld) r_dd[0] <= args[32*TJ +: 32];
        for (int i = 1; i < DL; i++)
          if (r_dv[i-1]) r_dd[i] <= r_dd[i-1];
      end

      a_term_align: assert property (@(posedge clk) disable iff (rst) r_dv[DL-1] == w_yv[k-1]);

`ifdef NESTED_SQRT_SAT_EN
      logic [32:0]  w_sum;
      logic         r_xo;
      logic [S-1:0] r_ovp;
      assign w_sum = {1'b0, r_dd[DL-1]} + {1'b0, w_y[k-1]};
      assign w_xin = w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];

      always_ff @(posedge clk) begin
        if (w_yv[k-1]) r_xo <= w_ovf[k-1] | w_sum[32];
      end

      // Overflow flag rides beside the isqrt pipeline, cleared where no vector is present.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovp <= '0;
        end else begin
          r_ovp[0] <= r_xv & r_xo;
          for (int i = 1; i < S; i++) r_ovp[i] <= r_ovp[i-1];
        end
      end
      assign w_ovf[k] = r_ovp[S-1];
`else
      assign w_xin = r_dd[DL-1] + w_y[k-1];
`endif

      always_ff @(posedge clk) begin
        if (w_yv[k-1]) r_x <= w_xin;
      end

      always_ff @(posedge clk) begin
        if (rst) r_xv <= 1'b0;
        else     r_xv <= w_yv[k-1];
      end

      isqrt #(.n_pipe_stages(S)) u_isqrt (
        .clk(clk), .rst(rst),
        .x_vld(r_xv), .x(r_x),
        .y_vld(w_yv[k]), .y(w_y[k])
      );
    end
  end

  assign res_vld = w_yv[N_LEVELS-1];
  assign res     = w_y[N_LEVELS-1];
`ifdef NESTED_SQRT_SAT_EN
  assign res_ovf = w_yv[N_LEVELS-1] & w_ovf[N_LEVELS-1];
`else
  assign res_ovf = 1'b0;
`endif

  logic [IFW-1:0] r_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      case ({arg_vld, res_vld})
        2'b10:   r_cnt <= r_cnt + IFW'(1);
        2'b01:   r_cnt <= r_cnt - IFW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign in_flight = r_cnt;
  assign idle      = (r_cnt == '0);
endmodule

// File: tb/tb_nested_sqrt_pipe.sv
// Directed bench for nested_sqrt_pipe: default build plus 1-level and 5-level variants.
module tb_nested_sqrt_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        vld_a, res_vld_a, res_ovf_a, idle_a;
  logic [95:0] args_a;
  logic [31:0] res_a;
  logic [5:0]  flt_a;

  logic        vld_b, res_vld_b, res_ovf_b, idle_b;
  logic [31:0] args_b, res_b;
  logic [2:0]  flt_b;

  logic         vld_c, res_vld_c, res_ovf_c, idle_c;
  logic [159:0] args_c;
  logic [31:0]  res_c;
  logic [3:0]   flt_c;

  nested_sqrt_pipe u_a (
    .clk(clk), .rst(rst), .arg_vld(vld_a), .args(args_a),
    .res_vld(res_vld_a), .res(res_a), .res_ovf(res_ovf_a), .in_flight(flt_a), .idle(idle_a)
  );
  nested_sqrt_pipe #(.N_LEVELS(1), .ISQRT_STAGES(4)) u_b (
    .clk(clk), .rst(rst), .arg_vld(vld_b), .args(args_b),
    .res_vld(res_vld_b), .res(res_b), .res_ovf(res_ovf_b), .in_flight(flt_b), .idle(idle_b)
  );
  nested_sqrt_pipe #(.N_LEVELS(5), .ISQRT_STAGES(2)) u_c (
    .clk(clk), .rst(rst), .arg_vld(vld_c), .args(args_c),
    .res_vld(res_vld_c), .res(res_c), .res_ovf(res_ovf_c), .in_flight(flt_c), .idle(idle_c)
  );

  int errs = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] isqrt_ref(input logic [31:0] x);
    longint lo = 0, hi = 65535, mid;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(x)) lo = mid;
      else hi = mid - 1;
    end
    return 32'(lo);
  endfunction

  function automatic logic [32:0] add_ref(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef NESTED_SQRT_SAT_EN
    if (s[32]) s = {1'b1, 32'hFFFF_FFFF};
`endif
    return s;
  endfunction

  task automatic nest_ref(input logic [31:0] t0, t1, t2, output logic [31:0] r, output logic o);
    logic [32:0] s1, s0;
    s1 = add_ref(t1, isqrt_ref(t2));
    s0 = add_ref(t0, isqrt_ref(s1[31:0]));
    r = isqrt_ref(s0[31:0]);
`ifdef NESTED_SQRT_SAT_EN
    o = s1[32] | s0[32];
`else
    o = 1'b0;
`endif
  endtask

  typedef struct {
    string       name;
    logic [31:0] t0, t1, t2, er;
    logic        eo;
  } vec_t;

  vec_t tv[8];

  logic        ev [400];
  logic [31:0] erv [400];
  logic        eov [400];

  initial begin
    int cyc, cb, cc, m, peak;
    logic [31:0] rb, rc, t0, t1, t2, r;
    logic flight_ok, seen, o, v;

    tv[0] = '{"t9_5_16",   32'd9,         32'd5,  32'd16, 32'd3,  1'b0};
    tv[1] = '{"t0_0_16",   32'd0,         32'd0,  32'd16, 32'd1,  1'b0};
    tv[2] = '{"zeros",     32'd0,         32'd0,  32'd0,  32'd0,  1'b0};
    tv[3] = '{"outer100",  32'd100,       32'd0,  32'd0,  32'd10, 1'b0};
    tv[4] = '{"big_inner", 32'd1000000,   32'd3,  32'd1,  32'd1000, 1'b0};
    tv[5] = '{"t7_10_35",  32'd7,         32'd10, 32'd35, 32'd3,  1'b0};
    tv[6] = '{"max_outer", 32'hFFFF_FFFF, 32'd0,  32'd0,  32'd65535, 1'b0};
`ifdef NESTED_SQRT_SAT_EN
    tv[7] = '{"ovf_sat",   32'hFFFF_FFFF, 32'd0,  32'd1,  32'd65535, 1'b1};
`else
    tv[7] = '{"ovf_wrap",  32'hFFFF_FFFF, 32'd0,  32'd1,  32'd0,  1'b0};
`endif

    rst = 1'b1;
    vld_a = 1'b0; vld_b = 1'b0; vld_c = 1'b0;
    args_a = '0; args_b = '0; args_c = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_res_vld", res_vld_a, 0);
    chk("rst_res_ovf", res_ovf_a, 0);
    chk("rst_in_flight", flt_a, 0);
    chk("rst_idle", idle_a, 1);
    chk("rst_res_vld_b", res_vld_b, 0);
    chk("rst_res_vld_c", res_vld_c, 0);

    for (int i = 0; i < 8; i++) begin
      args_a = {tv[i].t2, tv[i].t1, tv[i].t0};
      vld_a = 1'b1;
      step();
      vld_a = 1'b0;
      cyc = 1;
      flight_ok = 1'b1;
      while (!res_vld_a && cyc < 60) begin
        if (flt_a != 6'd1 || idle_a) flight_ok = 1'b0;
        step();
        cyc++;
      end
      chk({tv[i].name, "_latency"}, cyc, 50);
      chk({tv[i].name, "_res"}, res_a, tv[i].er);
      chk({tv[i].name, "_ovf"}, res_ovf_a, tv[i].eo);
      chk({tv[i].name, "_flight_during"}, flight_ok, 1);
      chk({tv[i].name, "_flight_at_out"}, flt_a, 1);
      step();
      chk({tv[i].name, "_single_pulse"}, res_vld_a, 0);
      chk({tv[i].name, "_flight_after"}, flt_a, 0);
      chk({tv[i].name, "_idle_after"}, idle_a, 1);
    end

    // Degenerate single level and a deep, short-stage chain.
    args_b = 32'd100;
    args_c = {32'd256, 128'd0};
    vld_b = 1'b1; vld_c = 1'b1;
    step();
    vld_b = 1'b0; vld_c = 1'b0;
    cb = -1; cc = -1; rb = '0; rc = '0;
    for (int c = 1; c <= 20; c++) begin
      if (res_vld_b && cb < 0) begin cb = c; rb = res_b; end
      if (res_vld_c && cc < 0) begin cc = c; rc = res_c; end
      step();
    end
    chk("n1_latency", cb, 4);
    chk("n1_res", rb, 10);
    chk("n5_latency", cc, 14);
    chk("n5_res", rc, 1);
    chk("n5_idle", idle_c, 1);

    // Mid-stream reset discards everything already accepted.
    for (int i = 0; i < 10; i++) begin
      args_a = {32'(i + 1), 32'd4, 32'd16};
      vld_a = 1'b1;
      step();
    end
    vld_a = 1'b0;
    for (int i = 10; i < 20; i++) step();
    chk("pre_rst_flight", flt_a, 10);
    rst = 1'b1;
    vld_a = 1'b1;
    step();
    rst = 1'b0;
    vld_a = 1'b0;
    chk("post_rst_flight", flt_a, 0);
    chk("post_rst_idle", idle_a, 1);
    seen = 1'b0;
    for (int i = 0; i < 70; i++) begin
      if (res_vld_a) seen = 1'b1;
      step();
    end
    chk("post_rst_no_vld", seen, 0);

    // Stream: solid burst then random gaps; output must replay the input pattern 50 cycles later.
    for (int i = 0; i < 400; i++) begin ev[i] = 1'b0; erv[i] = '0; eov[i] = 1'b0; end
    m = 0;
    peak = 0;
    for (int c = 0; c < 280; c++) begin
      chk("stream_vld", res_vld_a, ev[c]);
      if (ev[c]) begin
        chk("stream_res", res_a, erv[c]);
        chk("stream_ovf", res_ovf_a, eov[c]);
      end
      chk("stream_flight", flt_a, m);
      if (int'(flt_a) > peak) peak = int'(flt_a);
      v = (c < 60) ? 1'b1 : ((c < 200) ? ($urandom_range(0, 2) != 0) : 1'b0);
      case ($urandom_range(0, 2))
        0:       begin t0 = $urandom; t1 = $urandom; t2 = $urandom; end
        1:       begin t0 = $urandom_range(0, 1000); t1 = $urandom_range(0, 1000); t2 = $urandom; end
        default: begin t0 = 32'hFFFF_FFF0 + $urandom_range(0, 15); t1 = $urandom; t2 = $urandom; end
      endcase
      args_a = {t2, t1, t0};
      vld_a = v;
      if (v) begin
        nest_ref(t0, t1, t2, r, o);
        ev[c+50] = 1'b1;
        erv[c+50] = r;
        eov[c+50] = o;
      end
      m = m + (v ? 1 : 0) - (ev[c] ? 1 : 0);
      step();
    end
    vld_a = 1'b0;
    chk("stream_peak", peak, 50);
    chk("stream_idle_end", idle_a, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
